// File: rtl/gowin_sp_bsram.sv
// Single-port synchronous block RAM matching the Gowin SP BSRAM primitive.
// Ports: clk, rst_n, ce, oce, wre, ad, din -> dout (registered read data).
module gowin_sp_bsram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int READ_MODE  = 0,
  parameter int WRITE_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  oce,
  input  logic                  wre,
  input  logic [ADDR_WIDTH-1:0] ad,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(DEPTH);

  // Power-up image is all zeros; rst_n never touches it.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic                  in_range;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_en;
  logic                  wr_en;
  logic                  wr_thru;
  logic                  wr_rbw;
  logic [DATA_WIDTH-1:0] q1;
  logic [DATA_WIDTH-1:0] q1_nxt;

  assign in_range = {1'b0, ad} < DEPTH_W;
  assign idx      = ad[IW-1:0];

  // Out-of-range addresses read as zero.
  assign rd_word = in_range ? mem[idx] : '0;

  assign rd_en   = ce & ~wre;
  assign wr_en   = ce & wre;
  assign wr_thru = wr_en & (WRITE_MODE == 1);
  assign wr_rbw  = wr_en & (WRITE_MODE == 2);

  // rst_n gates the write so an edge inside reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en && in_range) begin
      mem[idx] <= din;
    end
  end

  always_comb begin
    q1_nxt = q1;
    unique case (1'b1)
      rd_en:   q1_nxt = rd_word;
      wr_thru: q1_nxt = din;
      wr_rbw:  q1_nxt = rd_word;
      default: q1_nxt = q1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
    end else begin
      q1 <= q1_nxt;
    end
  end

  generate
    if (READ_MODE == 1) begin : g_pipe
      logic [DATA_WIDTH-1:0] q2;
      // Output stage runs on oce alone, not ce.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q2 <= '0;
        end else if (oce) begin
          q2 <= q1;
        end
      end
      assign dout = q2;
    end else begin : g_bypass
      logic unused_oce;
      assign unused_oce = oce;
      assign dout       = q1;
    end
  endgenerate

endmodule

// File: tb/tb_gowin_sp_bsram.sv
// Self-checking bench for gowin_sp_bsram across several configurations.
// Drives shared traffic and compares every instance against a model.
module tb_gowin_sp_bsram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce, oce, wre;
  logic [10:0] ad;
  logic [31:0] din;
  logic [12:0] ad_a;
  logic [9:0]  din_a;
  logic [31:0] d_def, d_wm1, d_wm2, d_rm, d_sm;
  logic [9:0]  d_adc;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [2048];
  logic [31:0] s_mem [2048];
  logic [9:0]  a_mem [8192];
  logic [31:0] e_def, e_wm1, e_wm2, e_rq, e_rd, e_sm;
  logic [9:0]  e_adc;

  always #5 clk = ~clk;

  gowin_sp_bsram u_def (
    .clk(clk), .rst_n(rst_n), .ce(ce), .oce(oce), .wre(wre),
    .ad(ad), .din(din), .dout(d_def));

  gowin_sp_bsram #(.WRITE_MODE(1)) u_wm1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .oce(oce), .wre(wre),
    .ad(ad), .din(din), .dout(d_wm1));

  gowin_sp_bsram #(.WRITE_MODE(2)) u_wm2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .oce(oce), .wre(wre),
    .ad(ad), .din(din), .dout(d_wm2));

  gowin_sp_bsram #(.READ_MODE(1)) u_rm (
    .clk(clk), .rst_n(rst_n), .ce(ce), .oce(oce), .wre(wre),
    .ad(ad), .din(din), .dout(d_rm));

  gowin_sp_bsram #(.DEPTH(1500)) u_sm (
    .clk(clk), .rst_n(rst_n), .ce(ce), .oce(oce), .wre(wre),
    .ad(ad), .din(din), .dout(d_sm));

  gowin_sp_bsram #(.DATA_WIDTH(10), .ADDR_WIDTH(13)) u_adc (
    .clk(clk), .rst_n(rst_n), .ce(ce), .oce(oce), .wre(wre),
    .ad(ad_a), .din(din_a), .dout(d_adc));

  // What each instance should show, from the stored words and the op.
  task automatic model_edge();
    logic [31:0] old;
    if (!rst_n) begin
      e_def = 0; e_wm1 = 0; e_wm2 = 0;
      e_rq = 0; e_rd = 0; e_sm = 0; e_adc = 0;
      return;
    end
    if (oce) e_rd = e_rq;
    if (ce && wre) begin
      old = m_mem[ad];
      m_mem[ad] = din;
      e_wm1 = din;
      e_wm2 = old;
      if (ad < 1500) s_mem[ad] = din;
      a_mem[ad_a] = din_a;
    end else if (ce) begin
      e_def = m_mem[ad];
      e_wm1 = m_mem[ad];
      e_wm2 = m_mem[ad];
      e_rq  = m_mem[ad];
      e_sm  = (ad < 1500) ? s_mem[ad] : 32'h0;
      e_adc = a_mem[ad_a];
    end
  endtask

  task automatic cyc(input logic c, input logic w,
                     input logic [10:0] a, input logic [31:0] d,
                     input logic o, input logic [12:0] aa,
                     input logic [9:0] da);
    ce = c; wre = w; ad = a; din = d;
    oce = o; ad_a = aa; din_a = da;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 11'd5, 32'hDEADBEEF, 1, 13'd5, 10'h2AA);
      checks++;
      if (d_def !== 32'h0 || d_rm !== 32'h0 || d_adc !== 10'h0) begin
        errors++;
        $display("FAIL reset_hold def=%h rm=%h adc=%h want 0",
                 d_def, d_rm, d_adc);
      end
    end
    rst_n = 1'b1;
    cyc(1, 0, 11'd5, 32'h0, 1, 13'd5, 10'h0);
    checks++;
    if (d_def !== 32'h0 || d_adc !== 10'h0) begin
      errors++;
      $display("FAIL reset_drop def=%h adc=%h want 0", d_def, d_adc);
    end
  endtask

  task automatic test_write_read();
    cyc(1, 1, 11'd0, 32'h12345678, 1, 13'd8191, 10'h3FF);
    cyc(1, 1, 11'd2047, 32'hCAFEF00D, 1, 13'd0, 10'h155);
    cyc(1, 0, 11'd0, 32'h0, 1, 13'd8191, 10'h0);
    checks++;
    if (d_def !== 32'h12345678) begin
      errors++;
      $display("FAIL rd_ad0 got %h want 12345678", d_def);
    end
    checks++;
    if (d_adc !== 10'h3FF) begin
      errors++;
      $display("FAIL adc_rd_top got %h want 3ff", d_adc);
    end
    cyc(1, 0, 11'd2047, 32'h0, 1, 13'd0, 10'h0);
    checks++;
    if (d_def !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rd_ad2047 got %h want cafef00d", d_def);
    end
    checks++;
    if (d_adc !== 10'h155) begin
      errors++;
      $display("FAIL adc_rd_zero got %h want 155", d_adc);
    end
  endtask

  task automatic test_ce_gating();
    cyc(1, 1, 11'd9, 32'hA5A5A5A5, 1, 13'd100, 10'h0);
    cyc(1, 0, 11'd9, 32'h0, 1, 13'd100, 10'h0);
    checks++;
    if (d_def !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL ce_first got %h want a5a5a5a5", d_def);
    end
    cyc(0, 1, 11'd9, 32'h0, 1, 13'd100, 10'h0);
    cyc(0, 1, 11'd9, 32'h0, 1, 13'd100, 10'h0);
    checks++;
    if (d_def !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL ce_hold got %h want a5a5a5a5", d_def);
    end
    cyc(1, 0, 11'd9, 32'h0, 1, 13'd100, 10'h0);
    checks++;
    if (d_def !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL ce_noWrite got %h want a5a5a5a5", d_def);
    end
  endtask

  task automatic test_write_modes();
    cyc(1, 1, 11'd3, 32'h11, 1, 13'd3, 10'h0);
    cyc(1, 0, 11'd9, 32'h0, 1, 13'd3, 10'h0);
    cyc(1, 1, 11'd3, 32'h22, 1, 13'd3, 10'h0);
    checks++;
    if (d_def !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL wm0_hold got %h want a5a5a5a5", d_def);
    end
    checks++;
    if (d_wm1 !== 32'h22) begin
      errors++;
      $display("FAIL wm1_thru got %h want 22", d_wm1);
    end
    checks++;
    if (d_wm2 !== 32'h11) begin
      errors++;
      $display("FAIL wm2_rbw got %h want 11", d_wm2);
    end
  endtask

  task automatic test_pipeline();
    cyc(1, 1, 11'd7, 32'h77, 1, 13'd7, 10'h0);
    cyc(1, 0, 11'd7, 32'h0, 1, 13'd7, 10'h0);
    checks++;
    if (d_rm !== e_rd || d_rm === 32'h77) begin
      errors++;
      $display("FAIL pipe_edge1 got %h want %h", d_rm, e_rd);
    end
    cyc(0, 0, 11'd7, 32'h0, 1, 13'd7, 10'h0);
    checks++;
    if (d_rm !== 32'h77) begin
      errors++;
      $display("FAIL pipe_edge2 got %h want 77", d_rm);
    end
    cyc(1, 1, 11'd8, 32'h99, 0, 13'd8, 10'h0);
    cyc(1, 0, 11'd8, 32'h0, 0, 13'd8, 10'h0);
    cyc(0, 0, 11'd8, 32'h0, 0, 13'd8, 10'h0);
    cyc(0, 0, 11'd8, 32'h0, 0, 13'd8, 10'h0);
    checks++;
    if (d_rm !== 32'h77) begin
      errors++;
      $display("FAIL pipe_oce_hold got %h want 77", d_rm);
    end
    cyc(0, 0, 11'd8, 32'h0, 1, 13'd8, 10'h0);
    checks++;
    if (d_rm !== 32'h99) begin
      errors++;
      $display("FAIL pipe_oce_rise got %h want 99", d_rm);
    end
    ce = 1; wre = 0; ad = 11'd7; oce = 1;
    #2;
    rst_n = 1'b0;
    model_edge();
    #1;
    checks++;
    if (d_rm !== 32'h0 || d_def !== 32'h0 || d_wm2 !== 32'h0) begin
      errors++;
      $display("FAIL async_rst rm=%h def=%h wm2=%h want 0",
               d_rm, d_def, d_wm2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 11'd7, 32'h0, 1, 13'd7, 10'h0);
    cyc(0, 0, 11'd7, 32'h0, 1, 13'd7, 10'h0);
    checks++;
    if (d_rm !== 32'h77) begin
      errors++;
      $display("FAIL mem_kept got %h want 77", d_rm);
    end
  endtask

  task automatic test_out_of_range();
    cyc(1, 1, 11'd1600, 32'hBAD0BAD0, 1, 13'd0, 10'h0);
    cyc(1, 1, 11'd1499, 32'h00C0FFEE, 1, 13'd0, 10'h0);
    cyc(1, 0, 11'd1600, 32'h0, 1, 13'd0, 10'h0);
    checks++;
    if (d_sm !== 32'h0) begin
      errors++;
      $display("FAIL oor_read got %h want 0", d_sm);
    end
    checks++;
    if (d_def !== 32'hBAD0BAD0) begin
      errors++;
      $display("FAIL full_1600 got %h want bad0bad0", d_def);
    end
    cyc(1, 0, 11'd1499, 32'h0, 1, 13'd0, 10'h0);
    checks++;
    if (d_sm !== 32'h00C0FFEE) begin
      errors++;
      $display("FAIL last_word got %h want c0ffee", d_sm);
    end
  endtask

  function automatic logic [10:0] pick_ad();
    case ($urandom_range(0, 2))
      0:       return 11'($urandom_range(0, 15));
      1:       return 11'($urandom_range(1490, 1510));
      default: return 11'($urandom_range(2040, 2047));
    endcase
  endfunction

  task automatic test_random();
    logic [12:0] aa;
    for (int i = 0; i < 400; i++) begin
      aa = ($urandom_range(0, 1) == 0) ?
           13'($urandom_range(0, 15)) :
           13'($urandom_range(8180, 8191));
      cyc(1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)),
          pick_ad(), $urandom(),
          1'($urandom_range(0, 3) != 0),
          aa, 10'($urandom()));
      checks++;
      if (d_def !== e_def || d_wm1 !== e_wm1 || d_wm2 !== e_wm2) begin
        errors++;
        $display("FAIL rnd_rd i=%0d def=%h/%h wm1=%h/%h wm2=%h/%h",
                 i, d_def, e_def, d_wm1, e_wm1, d_wm2, e_wm2);
      end
      checks++;
      if (d_rm !== e_rd || d_sm !== e_sm || d_adc !== e_adc) begin
        errors++;
        $display("FAIL rnd_misc i=%0d rm=%h/%h sm=%h/%h adc=%h/%h",
                 i, d_rm, e_rd, d_sm, e_sm, d_adc, e_adc);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      m_mem[i] = 0;
      s_mem[i] = 0;
    end
    for (int i = 0; i < 8192; i++) a_mem[i] = 0;
    e_def = 0; e_wm1 = 0; e_wm2 = 0;
    e_rq = 0; e_rd = 0; e_sm = 0; e_adc = 0;
    rst_n = 1'b1;
    ce = 0; oce = 0; wre = 0; ad = 0; din = 0;
    ad_a = 0; din_a = 0;
    #2;
    rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_ce_gating();
    test_write_modes();
    test_pipeline();
    test_out_of_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
